// File: rtl/dp_ram_bist.sv
// Dual-port RAM built-in self test.
// Runs four phases: W0 writes E(a) = seed + a, R0 reads it back, W1 writes ~E(a),
// R1 reads that back. Each read is compared one cycle after it is issued against
// a delayed copy of the expected word. Mismatches are counted (saturating), and
// the address and phase of the first one are kept. All outputs are registered and
// line up with the FSM state that produced them.
module dp_ram_bist #(
   parameter int ADDR_SIZE = 4,
   parameter int DATA_SIZE = 32,
   parameter int DEPTH     = 2**ADDR_SIZE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [DATA_SIZE-1:0]   seed,
   output logic                   ram_wr,
   output logic [ADDR_SIZE-1:0]   ram_wr_addr,
   output logic [DATA_SIZE-1:0]   ram_data_in,
   output logic                   ram_rd,
   output logic [ADDR_SIZE-1:0]   ram_rd_addr,
   input  logic [DATA_SIZE-1:0]   ram_data_out,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [ADDR_SIZE+1:0]   err_count,
   output logic [ADDR_SIZE-1:0]   fail_addr,
   output logic                   fail_phase
);

   // One extra counter bit lets the read phases reach the drain slot (DEPTH)
   // without wrapping back to address 0.
   typedef logic [ADDR_SIZE:0]   cnt_t;
   typedef logic [ADDR_SIZE+1:0] err_t;

   localparam cnt_t LAST_ADDR  = cnt_t'(DEPTH - 1);
   localparam cnt_t DRAIN_ADDR = cnt_t'(DEPTH);
   localparam err_t ERR_MAX    = err_t'(2 * DEPTH);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] W0   = 3'd1;
   localparam logic [2:0] R0   = 3'd2;
   localparam logic [2:0] W1   = 3'd3;
   localparam logic [2:0] R1   = 3'd4;
   localparam logic [2:0] DONE = 3'd5;

   logic [2:0]           state_q, state_d;
   cnt_t                 addr_q, addr_d;
   logic [DATA_SIZE-1:0] seed_q, seed_d;
   err_t                 err_q, err_d;
   logic [ADDR_SIZE-1:0] fail_addr_q, fail_addr_d;
   logic                 fail_phase_q, fail_phase_d;
   logic                 wr_q, wr_d;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_SIZE-1:0] data_in_q, data_in_d;
   logic                 rd_q, rd_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic                 cmp_valid_q, cmp_valid_d;
   logic [ADDR_SIZE-1:0] cmp_addr_q, cmp_addr_d;
   logic                 cmp_phase_q, cmp_phase_d;
   logic [DATA_SIZE-1:0] cmp_exp_q, cmp_exp_d;

   logic                 accept;
   logic                 mismatch;
   logic [DATA_SIZE-1:0] wr_pattern;
   logic [DATA_SIZE-1:0] rd_pattern;

   // Next-state, compare and registered-output computation.
   // NOTE: every signal assigned here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      seed_d       = seed_q;
      err_d        = err_q;
      fail_addr_d  = fail_addr_q;
      fail_phase_d = fail_phase_q;
      wr_addr_d    = wr_addr_q;
      data_in_d    = data_in_q;
      rd_addr_d    = rd_addr_q;

      accept   = start && ((state_q == IDLE) || (state_q == DONE));
      mismatch = cmp_valid_q && (ram_data_out != cmp_exp_q);

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d      = W0;
               addr_d       = '0;
               seed_d       = seed;
               err_d        = '0;
               fail_addr_d  = '0;
               fail_phase_d = 1'b0;
            end
         end
         W0, W1: begin
            if (addr_q == LAST_ADDR) begin
               state_d = (state_q == W0) ? R0 : R1;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         R0, R1: begin
            if (addr_q == DRAIN_ADDR) begin
               state_d = (state_q == R0) ? W1 : DONE;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            addr_d  = '0;
         end
      endcase

      // Compare results never overlap an accepted start: no read is in flight
      // in IDLE or DONE.
      if (mismatch) begin
         if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
         end
         if (err_q == '0) begin
            fail_addr_d  = cmp_addr_q;
            fail_phase_d = cmp_phase_q;
         end
      end

      // RAM port controls follow the next state, so they are valid in the same
      // cycle the FSM occupies that state.
      wr_d       = (state_d == W0) || (state_d == W1);
      rd_d       = ((state_d == R0) || (state_d == R1)) && (addr_d != DRAIN_ADDR);
      wr_pattern = seed_d + DATA_SIZE'(addr_d);
      if (wr_d) begin
         wr_addr_d = addr_d[ADDR_SIZE-1:0];
         data_in_d = (state_d == W1) ? ~wr_pattern : wr_pattern;
      end
      if (rd_d) begin
         rd_addr_d = addr_d[ADDR_SIZE-1:0];
      end

      // Expected data travels one cycle behind the read issue to meet the
      // registered RAM output.
      rd_pattern  = seed_q + DATA_SIZE'(rd_addr_q);
      cmp_valid_d = rd_q;
      cmp_addr_d  = rd_addr_q;
      cmp_phase_d = (state_q == R1);
      cmp_exp_d   = cmp_phase_d ? ~rd_pattern : rd_pattern;

      busy_d = (state_d == W0) || (state_d == R0) || (state_d == W1) || (state_d == R1);
      done_d = (state_d == DONE);
      // The verdict is taken on entry to DONE and includes the final compare.
      if (state_d != DONE) begin
         pass_d = 1'b0;
      end else if (state_q != DONE) begin
         pass_d = (err_d == '0);
      end else begin
         pass_d = pass_q;
      end
   end

   // State and output registers with asynchronous reset.
   // NOTE: non-blocking assignments here so every register samples the values
   // of the previous cycle regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         seed_q       <= '0;
         err_q        <= '0;
         fail_addr_q  <= '0;
         fail_phase_q <= 1'b0;
         wr_q         <= 1'b0;
         wr_addr_q    <= '0;
         data_in_q    <= '0;
         rd_q         <= 1'b0;
         rd_addr_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         cmp_valid_q  <= 1'b0;
         cmp_addr_q   <= '0;
         cmp_phase_q  <= 1'b0;
         cmp_exp_q    <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         seed_q       <= seed_d;
         err_q        <= err_d;
         fail_addr_q  <= fail_addr_d;
         fail_phase_q <= fail_phase_d;
         wr_q         <= wr_d;
         wr_addr_q    <= wr_addr_d;
         data_in_q    <= data_in_d;
         rd_q         <= rd_d;
         rd_addr_q    <= rd_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         cmp_valid_q  <= cmp_valid_d;
         cmp_addr_q   <= cmp_addr_d;
         cmp_phase_q  <= cmp_phase_d;
         cmp_exp_q    <= cmp_exp_d;
      end
   end

   assign ram_wr      = wr_q;
   assign ram_wr_addr = wr_addr_q;
   assign ram_data_in = data_in_q;
   assign ram_rd      = rd_q;
   assign ram_rd_addr = rd_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign err_count   = err_q;
   assign fail_addr   = fail_addr_q;
   assign fail_phase  = fail_phase_q;

endmodule

// File: tb/tb_dp_ram_bist.sv
// Testbench for dp_ram_bist: a registered-read RAM with injectable faults, a
// monitor logging every RAM access, and a reference model that derives the
// expected verdict and access sequence directly from the pattern rules.
module tb_dp_ram_bist;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] seed = '0;
   logic          ram_wr;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] ram_data_in;
   logic          ram_rd;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_data_out = '0;
   logic          busy;
   logic          done;
   logic          pass;
   logic [AW+1:0] err_count;
   logic [AW-1:0] fail_addr;
   logic          fail_phase;

   dp_ram_bist #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .seed         (seed),
      .ram_wr       (ram_wr),
      .ram_wr_addr  (ram_wr_addr),
      .ram_data_in  (ram_data_in),
      .ram_rd       (ram_rd),
      .ram_rd_addr  (ram_rd_addr),
      .ram_data_out (ram_data_out),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .err_count    (err_count),
      .fail_addr    (fail_addr),
      .fail_phase   (fail_phase)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cycle    = 0;
   int e0       = 0;

   // Fault injection: stuck bit over an address range, or all reads inverted.
   bit f_en  = 1'b0;
   bit f_inv = 1'b0;
   int f_lo  = 0;
   int f_hi  = 0;
   int f_bit = 0;
   bit f_val = 1'b0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           wr_log[$];
   logic [AW-1:0] rd_log[$];
   int            overlaps = 0;

   logic [DW-1:0] mem [DEPTH];

   function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] d, input int a);
      logic [DW-1:0] r;
      r = d;
      if (f_inv) r = ~r;
      if (f_en && a >= f_lo && a <= f_hi) r[f_bit] = f_val;
      return r;
   endfunction

   always @(posedge clk) cycle <= cycle + 1;

   // RAM with registered read port.
   always @(posedge clk) begin
      if (ram_wr) mem[ram_wr_addr] <= ram_data_in;
      if (ram_rd) ram_data_out <= corrupt(mem[ram_rd_addr], int'(ram_rd_addr));
   end

   // Access monitor.
   always @(negedge clk) begin
      if (ram_wr) wr_log.push_back({ram_wr_addr, ram_data_in});
      if (ram_rd) rd_log.push_back(ram_rd_addr);
      if (ram_wr && ram_rd) overlaps++;
   end

   // Reference verdict: walk both phases in order and apply the fault to E(a) / ~E(a).
   task automatic model(input logic [DW-1:0] s, output int errs, output int faddr,
                        output int fphase, output bit ok);
      logic [DW-1:0] e;
      errs = 0; faddr = 0; fphase = 0;
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < DEPTH; a++) begin
            e = s + DW'(a);
            if (p == 1) e = ~e;
            if (corrupt(e, a) != e) begin
               if (errs == 0) begin
                  faddr  = a;
                  fphase = p;
               end
               if (errs < 2 * DEPTH) errs++;
            end
         end
      end
      ok = (errs == 0);
   endtask

   task automatic launch(input logic [DW-1:0] s);
      @(negedge clk);
      wr_log.delete();
      rd_log.delete();
      overlaps = 0;
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cycle;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_accept: done=%b busy=%b, need done=0 busy=1", done, busy);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_check(input string name, input logic [DW-1:0] s);
      int  n = 0;
      int  errs, faddr, fphase, bad;
      bit  ok;
      wr_t w;
      logic [DW-1:0] d;
      while (done !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: done never rose in 200 cycles", name);
      end else if (cycle - e0 != 4 * DEPTH + 2) begin
         n_fail++;
         $display("FAIL %s latency: done after %0d edges, need %0d", name, cycle - e0, 4 * DEPTH + 2);
      end
      model(s, errs, faddr, fphase, ok);
      n_checks++;
      if (pass !== ok || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s verdict: pass=%b busy=%b, need pass=%b busy=0", name, pass, busy, ok);
      end
      n_checks++;
      if (int'(err_count) != errs) begin
         n_fail++;
         $display("FAIL %s err_count: got %0d need %0d", name, err_count, errs);
      end
      n_checks++;
      if (int'(fail_addr) != faddr || int'(fail_phase) != fphase) begin
         n_fail++;
         $display("FAIL %s first_fail: addr=%0d phase=%0d, need addr=%0d phase=%0d",
                  name, fail_addr, fail_phase, faddr, fphase);
      end
      bad = 0;
      if (wr_log.size() == 2 * DEPTH) begin
         for (int i = 0; i < 2 * DEPTH; i++) begin
            d = s + DW'(i % DEPTH);
            if (i >= DEPTH) d = ~d;
            w = wr_log[i];
            if (int'(w.a) != i % DEPTH || w.d !== d) bad++;
         end
      end
      n_checks++;
      if (wr_log.size() != 2 * DEPTH || bad != 0) begin
         n_fail++;
         $display("FAIL %s writes: count=%0d wrong=%0d, need count=%0d wrong=0",
                  name, wr_log.size(), bad, 2 * DEPTH);
      end
      bad = 0;
      if (rd_log.size() == 2 * DEPTH) begin
         for (int i = 0; i < 2 * DEPTH; i++) begin
            if (int'(rd_log[i]) != i % DEPTH) bad++;
         end
      end
      n_checks++;
      if (rd_log.size() != 2 * DEPTH || bad != 0) begin
         n_fail++;
         $display("FAIL %s reads: count=%0d wrong=%0d, need count=%0d wrong=0",
                  name, rd_log.size(), bad, 2 * DEPTH);
      end
      n_checks++;
      if (overlaps != 0) begin
         n_fail++;
         $display("FAIL %s overlap: wr and rd high together in %0d cycles, need 0", name, overlaps);
      end
   endtask

   task automatic clear_faults();
      f_en = 1'b0; f_inv = 1'b0; f_lo = 0; f_hi = 0; f_bit = 0; f_val = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({ram_wr, ram_rd, busy, done, pass, fail_phase} !== 6'b0 ||
          ram_wr_addr !== '0 || ram_rd_addr !== '0 || ram_data_in !== '0 ||
          err_count !== '0 || fail_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_state: wr=%b rd=%b busy=%b done=%b pass=%b err=%0d data=%h, need all 0",
                  ram_wr, ram_rd, busy, done, pass, err_count, ram_data_in);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fault_free();
      clear_faults();
      launch(32'h0000_0010);
      finish_check("fault_free", 32'h0000_0010);
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL done_hold: done=%b pass=%b, need 1 1", done, pass);
      end
   endtask

   task automatic test_wrap();
      wr_t w1, w2;
      clear_faults();
      launch(32'hFFFF_FFFF);
      finish_check("wrap", 32'hFFFF_FFFF);
      w1 = wr_log.size() > DEPTH + 1 ? wr_log[1] : '0;
      w2 = wr_log.size() > DEPTH + 1 ? wr_log[DEPTH + 1] : '0;
      n_checks++;
      if (w1.d !== 32'h0000_0000 || w2.d !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL wrap_words: E(1)=%h pass1(1)=%h, need 00000000 ffffffff", w1.d, w2.d);
      end
   endtask

   task automatic test_stuck_bit();
      clear_faults();
      f_en = 1'b1; f_lo = 5; f_hi = 5; f_bit = 0; f_val = 1'b0;
      launch(32'h0);
      finish_check("stuck_a5_b0", 32'h0);
      n_checks++;
      if (err_count !== 6'd1 || fail_addr !== 4'd5 || fail_phase !== 1'b0 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL stuck_literal: err=%0d addr=%0d phase=%b pass=%b, need 1 5 0 0",
                  err_count, fail_addr, fail_phase, pass);
      end
   endtask

   task automatic test_all_fail();
      clear_faults();
      f_inv = 1'b1;
      launch(32'h1234_5678);
      finish_check("all_fail", 32'h1234_5678);
   endtask

   task automatic test_random();
      logic [DW-1:0] s;
      for (int it = 0; it < 6; it++) begin
         clear_faults();
         s     = $urandom;
         f_en  = 1'($urandom_range(0, 1));
         f_lo  = $urandom_range(0, DEPTH - 1);
         f_hi  = $urandom_range(f_lo, DEPTH - 1);
         f_bit = $urandom_range(0, DW - 1);
         f_val = 1'($urandom_range(0, 1));
         launch(s);
         finish_check("random", s);
      end
   endtask

   task automatic test_start_ignored();
      clear_faults();
      launch(32'hA5A5_0000);
      repeat (9) @(negedge clk);
      seed  = 32'h0BAD_0BAD;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_ignored_busy: busy=%b, need 1", busy);
      end
      finish_check("start_ignored", 32'hA5A5_0000);
   endtask

   task automatic test_restart_from_done();
      clear_faults();
      launch(32'h0000_7777);
      finish_check("restart", 32'h0000_7777);
   endtask

   task automatic test_abort();
      int nw, nr;
      clear_faults();
      launch(32'hC0DE_0000);
      repeat (19) @(posedge clk);
      #1;
      n_checks++;
      if (ram_rd !== 1'b1 || ram_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_in_r0: rd=%b wr=%b, need rd=1 wr=0", ram_rd, ram_wr);
      end
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (ram_rd !== 1'b0 || ram_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: rd=%b wr=%b busy=%b done=%b, need all 0", ram_rd, ram_wr, busy, done);
      end
      nw = wr_log.size();
      nr = rd_log.size();
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++;
      if (wr_log.size() != nw || rd_log.size() != nr || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_quiet: writes %0d->%0d reads %0d->%0d busy=%b, need unchanged, busy=0",
                  nw, wr_log.size(), nr, rd_log.size(), busy);
      end
      launch(32'h0000_00F0);
      finish_check("after_abort", 32'h0000_00F0);
   endtask

   initial begin
      test_reset();
      test_fault_free();
      test_wrap();
      test_stuck_bit();
      test_all_fail();
      test_start_ignored();
      test_restart_from_done();
      test_random();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dp_ram_bist.md
DP_RAM_BIST -- requirements
Module: dp_ram_bist

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 4, meaning RAM address width.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32, meaning RAM data width.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_SIZE, meaning number of words tested.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle test request pulse.
REQ-007 seed  input  DATA_SIZE  pattern base, sampled with start.
REQ-008 ram_wr  output  1  write enable to RAM write port.
REQ-009 ram_wr_addr  output  ADDR_SIZE  RAM write address.
REQ-010 ram_data_in  output  DATA_SIZE  RAM write data.
REQ-011 ram_rd  output  1  read enable to RAM read port.
REQ-012 ram_rd_addr  output  ADDR_SIZE  RAM read address.
REQ-013 ram_data_out  input  DATA_SIZE  RAM registered read data, valid one cycle after ram_rd.
REQ-014 busy  output  1  test in progress.
REQ-015 done  output  1  test complete, held until next accepted start or reset.
REQ-016 pass  output  1  valid while done; 1 = zero mismatches.
REQ-017 err_count  output  ADDR_SIZE+2  total mismatches, both passes.
REQ-018 fail_addr  output  ADDR_SIZE  address of first mismatch; fail_phase  output  1  pass (0/1) of first mismatch.

Function
REQ-019 All outputs SHALL be registered; FSM states SHALL be IDLE, W0, R0, W1, R1, DONE.
REQ-020 start SHALL be accepted only in IDLE or DONE; accepting latches seed, clears err_count/fail_addr/fail_phase/done/pass, enters W0, busy=1; start in any other state SHALL be ignored.
REQ-021 Expected word E(a) SHALL be seed + a, modulo 2**DATA_SIZE; pass-1 pattern SHALL be ~E(a).
REQ-022 W0: one write per cycle, a = 0..DEPTH-1 ascending, ram_wr=1, data E(a); then R0.
REQ-023 R0: ram_rd=1 with a = 0..DEPTH-1 on DEPTH consecutive cycles, then one drain cycle with ram_rd=0; total DEPTH+1 cycles; then W1.
REQ-024 Compare SHALL occur the cycle after each read issue, against a one-cycle-delayed copy of expected data and address; DEPTH compares per read phase.
REQ-025 W1 and R1 SHALL mirror W0/R0 using ~E(a); R1 drain SHALL transition to DONE.
REQ-026 ram_wr and ram_rd SHALL never both be 1 in one cycle; outside W*/R* both SHALL be 0.
REQ-027 Each mismatch SHALL increment err_count by 1 (max 2*DEPTH, no wrap); first mismatch only SHALL load fail_addr and fail_phase.
REQ-028 Entering DONE: busy=0, done=1, pass=(err_count==0 including final compare).
REQ-029 Address counter SHALL be ADDR_SIZE+1 bits so DEPTH reaches drain without wrap.
REQ-030 Latency: with start sampled at edge E0, done SHALL be 1 after edge E0+4*DEPTH+2 (66 for DEPTH=16).

Reset
REQ-031 rst=1 SHALL immediately force IDLE; ram_wr, ram_rd, busy, done, pass=0; all addresses, ram_data_in, err_count, fail_addr, fail_phase=0.
REQ-032 Reset mid-test SHALL abort with no further RAM accesses; next start SHALL begin a full fresh test.

Verification
REQ-033 Fault-free RAM, seed=0x00000010, start -> W0 writes 0x10..0x1F at 0..15, done=1 at E0+66, pass=1, err_count=0.
REQ-034 Bit 0 at address 5 stuck-at-0, seed=0 -> err_count=1, fail_addr=5, fail_phase=0, pass=0.
REQ-035 seed=0xFFFFFFFF -> E(1)=0x00000000, pass-1 word at 1 = 0xFFFFFFFF; fault-free gives pass=1 (wrap check).
REQ-036 start pulsed again at E0+10 -> ignored, done still at E0+66; start while DONE -> restart, done=0 next cycle.
REQ-037 rst asserted during R0 -> ram_rd/ram_wr/busy=0 immediately, no RAM accesses until next start.
REQ-038 All runs: assert ram_wr and ram_rd never concurrently high, and exactly 2*DEPTH writes and 2*DEPTH reads per completed test.
